traffic_light_monitor: RTL and testbench

Passive checker on the traffic-light output interface: samples `ns_light`/`ew_light` every `clk` and tracks the expected phase sequence NS_GREEN → NS_YELLOW → EW_GREEN → EW_YELLOW → NS_GREEN. It reports encoding errors, conflicts, sequence violations and dwell-time violations, and counts completed cycles. It sits beside the traffic-light controller in the system and its testbench, and drives no light signal.

---
 rtl/traffic_light_pkg.sv | 67 ++++++
 rtl/traffic_dwell_ctr.sv | 28 ++
 rtl/traffic_light_monitor.sv | 140 ++++++++++++++
 tb/tb_traffic_light_monitor.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_light_pkg.sv
// Shared types and input decode for the traffic-light monitor.
// Resync behaviour is selected in the top by TRAFFIC_MON_RESYNC_EN.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    L_RED    = 2'b00,
    L_GREEN  = 2'b01,
    L_YELLOW = 2'b10,
    L_BAD    = 2'b11
  } light_t;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_NS_G  = 3'd1,
    PH_NS_Y  = 3'd2,
    PH_EW_G  = 3'd3,
    PH_EW_Y  = 3'd4,
    PH_FAULT = 3'd5
  } phase_t;

  typedef enum logic [2:0] {
    E_NONE     = 3'd0,
    E_CODE     = 3'd1,
    E_CONFLICT = 3'd2,
    E_SEQ      = 3'd3,
    E_SHORT    = 3'd4,
    E_LONG     = 3'd5
  } err_t;

  typedef struct packed {
    err_t   err;
    phase_t ph;
  } obs_t;

  // ph is PH_IDLE for all-red; err is set for unusable samples
  function automatic obs_t decode(light_t ns, light_t ew);
    obs_t o;
    o.err = E_NONE;
    o.ph  = PH_IDLE;
    if (ns == L_BAD || ew == L_BAD)
      o.err = E_CODE;
    else if (ns != L_RED && ew != L_RED)
      o.err = E_CONFLICT;
    else if (ns == L_GREEN)
      o.ph = PH_NS_G;
    else if (ns == L_YELLOW)
      o.ph = PH_NS_Y;
    else if (ew == L_GREEN)
      o.ph = PH_EW_G;
    else if (ew == L_YELLOW)
      o.ph = PH_EW_Y;
    return o;
  endfunction

  function automatic phase_t succ(phase_t p);
    phase_t n;
    unique case (p)
      PH_NS_G: n = PH_NS_Y;
      PH_NS_Y: n = PH_EW_G;
      PH_EW_G: n = PH_EW_Y;
      PH_EW_Y: n = PH_NS_G;
      default: n = p;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/traffic_dwell_ctr.sv
// Saturating dwell counter: clear, load-to-1, or increment up to sat_i.
// Used by traffic_light_monitor to time each phase.
module traffic_dwell_ctr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic         inc_i,
  input  logic [W-1:0] sat_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i)
      cnt_q <= '0;
    else if (load_i)
      cnt_q <= W'(1);
    else if (inc_i && cnt_q < sat_i)
      cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive phase/dwell checker for a two-way traffic light.
// Define TRAFFIC_MON_RESYNC_EN to resync after errors instead of latching FAULT.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int GREEN_MIN  = 5,
  parameter int GREEN_MAX  = 6,
  parameter int YELLOW_MIN = 2,
  parameter int YELLOW_MAX = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       ns_light,
  input  logic [1:0]       ew_light,
  output logic [2:0]       phase,
  output logic             err_pulse,
  output logic [2:0]       err_code,
  output logic             err_sticky,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int MAXD = (GREEN_MAX > YELLOW_MAX) ? GREEN_MAX : YELLOW_MAX;
  localparam int DW   = $clog2(MAXD + 2);

  phase_t           phase_q, phase_d;
  err_t             code_q, err_d;
  logic             pulse_q, sticky_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0]    dwell_q, min_c, max_c, sat_c;
  logic             load_c, inc_c, clr_c, cyc_c;
  obs_t             obs;

  always_comb obs = decode(light_t'(ns_light), light_t'(ew_light));

  always_comb begin
    if (phase_q == PH_NS_G || phase_q == PH_EW_G) begin
      min_c = DW'(GREEN_MIN);
      max_c = DW'(GREEN_MAX);
    end else begin
      min_c = DW'(YELLOW_MIN);
      max_c = DW'(YELLOW_MAX);
    end
    sat_c = max_c + 1'b1;
  end

  always_comb begin
    phase_d = phase_q;
    err_d   = E_NONE;
    load_c  = 1'b0;
    inc_c   = 1'b0;
    clr_c   = 1'b0;
    cyc_c   = 1'b0;
    unique case (phase_q)
      PH_IDLE: begin
        if (obs.err != E_NONE) begin
          err_d = obs.err;
        end else if (obs.ph != PH_IDLE) begin
          phase_d = obs.ph;
          load_c  = 1'b1;
        end
      end
      PH_NS_G, PH_NS_Y, PH_EW_G, PH_EW_Y: begin
        if (obs.err != E_NONE) begin
          err_d = obs.err;
        end else if (obs.ph == phase_q) begin
          inc_c = 1'b1;
          // fires only on the step to MAX+1; saturation keeps it single
          if (dwell_q == max_c)
            err_d = E_LONG;
        end else if (obs.ph == succ(phase_q)) begin
          if (dwell_q < min_c)
            err_d = E_SHORT;
          phase_d = obs.ph;
          load_c  = 1'b1;
          cyc_c   = (phase_q == PH_EW_Y);
        end else begin
          err_d = E_SEQ;
        end
      end
      default: ;
    endcase

`ifdef TRAFFIC_MON_RESYNC_EN
    if (err_d == E_CODE || err_d == E_CONFLICT) begin
      phase_d = PH_IDLE;
      load_c  = 1'b0;
      inc_c   = 1'b0;
      clr_c   = 1'b1;
    end else if (err_d == E_SEQ) begin
      phase_d = obs.ph;
      load_c  = (obs.ph != PH_IDLE);
      clr_c   = (obs.ph == PH_IDLE);
    end
`else
    if (err_d != E_NONE) begin
      phase_d = PH_FAULT;
      load_c  = 1'b0;
      inc_c   = 1'b0;
      cyc_c   = 1'b0;
    end
`endif
  end

  traffic_dwell_ctr #(.W(DW)) u_dwell (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr_c),
    .load_i (load_c),
    .inc_i  (inc_c),
    .sat_i  (sat_c),
    .cnt_o  (dwell_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= PH_IDLE;
      pulse_q  <= 1'b0;
      code_q   <= E_NONE;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      phase_q <= phase_d;
      pulse_q <= (err_d != E_NONE);
      if (err_d != E_NONE) begin
        code_q   <= err_d;
        sticky_q <= 1'b1;
      end
      if (cyc_c)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign phase       = phase_q;
  assign err_pulse   = pulse_q;
  assign err_code    = code_q;
  assign err_sticky  = sticky_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor (default and resync builds).
// Second instance with CNT_W=2 exercises counter wrap.
module tb_traffic_light_monitor;

`ifdef TRAFFIC_MON_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  ns = 2'b00;
  logic [1:0]  ew = 2'b00;
  logic [2:0]  phase, phase2;
  logic        err_pulse, err_pulse2;
  logic [2:0]  err_code, err_code2;
  logic        err_sticky, err_sticky2;
  logic [15:0] cycle_count;
  logic [1:0]  cycle_count2;

  always #5 clk = ~clk;

  traffic_light_monitor u_dut (
    .clk         (clk),
    .rst         (rst),
    .ns_light    (ns),
    .ew_light    (ew),
    .phase       (phase),
    .err_pulse   (err_pulse),
    .err_code    (err_code),
    .err_sticky  (err_sticky),
    .cycle_count (cycle_count)
  );

  traffic_light_monitor #(.CNT_W(2)) u_dut2 (
    .clk         (clk),
    .rst         (rst),
    .ns_light    (ns),
    .ew_light    (ew),
    .phase       (phase2),
    .err_pulse   (err_pulse2),
    .err_code    (err_code2),
    .err_sticky  (err_sticky2),
    .cycle_count (cycle_count2)
  );

  typedef struct {
    int ph;
    int pulse;
    int code;
    int sticky;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errs = 0;

  int m_ph = 0, m_dw = 0, m_code = 0, m_sticky = 0, m_pulse = 0;
  int unsigned m_cnt = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference behaviour written from the phase-table description
  task automatic model_step(input logic [1:0] ns_v, input logic [1:0] ew_v,
                            input bit r);
    int op, mn, mx, err;
    if (r) begin
      m_ph = 0; m_dw = 0; m_code = 0; m_sticky = 0; m_pulse = 0; m_cnt = 0;
      return;
    end
    m_pulse = 0;
    if (m_ph == 5) return;
    op = (ns_v == 2'd1) ? 1 : (ns_v == 2'd2) ? 2 :
         (ew_v == 2'd1) ? 3 : (ew_v == 2'd2) ? 4 : 0;
    mn = (m_ph == 1 || m_ph == 3) ? 5 : 2;
    mx = (m_ph == 1 || m_ph == 3) ? 6 : 3;
    err = 0;
    if (ns_v == 2'd3 || ew_v == 2'd3) err = 1;
    else if (ns_v != 2'd0 && ew_v != 2'd0) err = 2;
    else if (m_ph == 0) begin
      if (op != 0) begin m_ph = op; m_dw = 1; end
    end else if (op == m_ph) begin
      if (m_dw == mx) err = 5;
      if (m_dw <= mx) m_dw++;
    end else if (op == (m_ph % 4) + 1) begin
      if (m_dw < mn) err = 4;
      if (m_ph == 4 && (err == 0 || RESYNC)) m_cnt++;
      m_ph = op;
      m_dw = 1;
    end else err = 3;
    if (err != 0) begin
      m_pulse = 1; m_code = err; m_sticky = 1;
      if (!RESYNC) m_ph = 5;
      else if (err == 1 || err == 2) begin m_ph = 0; m_dw = 0; end
      else if (err == 3) begin m_ph = op; m_dw = (op != 0) ? 1 : 0; end
    end
  endtask

  task automatic step(input logic [1:0] ns_v, input logic [1:0] ew_v,
                      input bit r);
    exp_t e;
    @(negedge clk);
    rst = r; ns = ns_v; ew = ew_v;
    model_step(ns_v, ew_v, r);
    e.ph = m_ph; e.pulse = m_pulse; e.code = m_code;
    e.sticky = m_sticky; e.cnt = int'(m_cnt);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check("phase", int'(phase), e.ph);
      check("err_pulse", int'(err_pulse), e.pulse);
      check("err_code", int'(err_code), e.code);
      check("err_sticky", int'(err_sticky), e.sticky);
      check("cycle_count", int'(cycle_count), e.cnt % 65536);
      check("phase_w2", int'(phase2), e.ph);
      check("cycle_count_w2", int'(cycle_count2), e.cnt % 4);
    end
  endtask

  task automatic hold(input logic [1:0] ns_v, input logic [1:0] ew_v,
                      input int n);
    for (int i = 0; i < n; i++) step(ns_v, ew_v, 1'b0);
  endtask

  task automatic do_reset();
    step(2'b00, 2'b00, 1'b1);
  endtask

  task automatic full_cycle_tail();
    hold(2'b10, 2'b00, 2);
    hold(2'b00, 2'b01, 6);
    hold(2'b00, 2'b10, 3);
    hold(2'b01, 2'b00, 1);
  endtask

  initial begin
    int r;
    logic [1:0] rn, re;

    do_reset();
    check("rst_code", int'(err_code), 0);

    // legal run
    hold(2'b00, 2'b00, 2);
    hold(2'b01, 2'b00, 5);
    full_cycle_tail();
    check("legal_cnt", int'(cycle_count), 1);
    check("legal_sticky", int'(err_sticky), 0);

    // three more cycles: narrow counter wraps to 0
    for (int k = 0; k < 3; k++) begin
      hold(2'b01, 2'b00, 4);
      full_cycle_tail();
    end
    check("wrap_w2", int'(cycle_count2), 0);
    check("wrap_w16", int'(cycle_count), 4);

    // reset mid EW_G
    hold(2'b01, 2'b00, 4);
    hold(2'b10, 2'b00, 2);
    hold(2'b00, 2'b01, 3);
    do_reset();
    check("midrst_cnt", int'(cycle_count), 0);

    // illegal code during NS_G
    hold(2'b01, 2'b00, 2);
    step(2'b11, 2'b00, 1'b0);
    check("code_err", int'(err_code), 1);
    hold(2'b01, 2'b00, 3);
    do_reset();

    // CODE outranks SEQ
    hold(2'b01, 2'b00, 1);
    step(2'b11, 2'b01, 1'b0);
    check("code_vs_seq", int'(err_code), 1);
    do_reset();

    // sequence error, then later input
    hold(2'b01, 2'b00, 2);
    step(2'b00, 2'b01, 1'b0);
    check("seq_err", int'(err_code), 3);
    hold(2'b00, 2'b01, 5);
    hold(2'b00, 2'b10, 2);
    hold(2'b01, 2'b11, 1);
    do_reset();

    // short yellow
    hold(2'b01, 2'b00, 5);
    hold(2'b10, 2'b00, 1);
    step(2'b00, 2'b01, 1'b0);
    check("short_err", int'(err_code), 4);
    do_reset();

    // long green: single LONG on the 7th sample
    hold(2'b01, 2'b00, 5);
    hold(2'b10, 2'b00, 2);
    hold(2'b00, 2'b01, 7);
    check("long_err", int'(err_code), 5);
    check("long_pulse", int'(err_pulse), 1);
    step(2'b00, 2'b01, 1'b0);
    check("long_once", int'(err_pulse), 0);
    do_reset();

    // conflict
    step(2'b01, 2'b01, 1'b0);
    check("conflict_err", int'(err_code), 2);
    do_reset();

    // biased random traffic
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 19);
      if (m_ph == 5 && $urandom_range(0, 3) == 0) begin
        do_reset();
      end else begin
        int p;
        p = (r < 13) ? m_ph : (r < 18) ? (m_ph % 4) + 1 : 9;
        if (p == 0 || p == 5) p = $urandom_range(0, 4);
        unique case (p)
          1: begin rn = 2'b01; re = 2'b00; end
          2: begin rn = 2'b10; re = 2'b00; end
          3: begin rn = 2'b00; re = 2'b01; end
          4: begin rn = 2'b00; re = 2'b10; end
          9: begin
            rn = 2'($urandom_range(0, 3));
            re = 2'($urandom_range(0, 3));
          end
          default: begin rn = 2'b00; re = 2'b00; end
        endcase
        step(rn, re, 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
